// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder family: mode encoding,
// default geometry and a small helper for slice sizing.
package pipelined_adder_pkg;

   // Operation select carried on the sub input.
   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_SUB = 1'b1
   } mode_e;

   localparam int DEFAULT_WIDTH  = 8;
   localparam int DEFAULT_STAGES = 2;

   // Bits handled by each pipeline stage.
   function automatic int slice_width(input int width, input int stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/adder_slice.sv
// Purely combinational SW-bit adder slice with carry in and carry out.
// One instance sits in each pipeline stage; all state lives in the parent.
module adder_slice
   import pipelined_adder_pkg::*;
#(
   parameter int SW = 4
) (
   input  logic [SW-1:0] a,
   input  logic [SW-1:0] b,
   input  logic          ci,
   output logic [SW-1:0] s,
   output logic          co
);

   // Widen by one bit so the carry falls out of the top of the sum.
   assign {co, s} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, ci};

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined adder/subtractor. Operands are cut into STAGES slices;
// stage k adds slice k using the carry registered by stage k-1, while the
// not-yet-consumed operand slices ride along in skew registers. Legal
// geometry: WIDTH 2..64, STAGES 1..WIDTH with WIDTH divisible by STAGES.
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int STAGES = DEFAULT_STAGES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic             sub,
   input  logic             cin,
   output logic [WIDTH:0]   out,
   output logic             overflow,
   output logic             out_valid
);

   localparam int SW = slice_width(WIDTH, STAGES);
   localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SW{1'b1}});

   // Pipeline registers, one entry per stage. a_q/b_q carry the operands
   // forward (upper slices still unconsumed), sum_q accumulates result
   // slices 0..k, carry_q is the carry out of the slice summed in stage k.
   logic [WIDTH-1:0]  a_q     [STAGES];
   logic [WIDTH-1:0]  b_q     [STAGES];
   logic [WIDTH-1:0]  sum_q   [STAGES];
   logic              carry_q [STAGES];
   logic [STAGES-1:0] valid_q;
   logic              overflow_q;

   // Per-stage inputs (from the ports for stage 0, from the previous
   // stage's registers otherwise) and next-state values.
   logic [WIDTH-1:0]  a_src     [STAGES];
   logic [WIDTH-1:0]  b_src     [STAGES];
   logic [WIDTH-1:0]  sum_src   [STAGES];
   logic              carry_src [STAGES];
   logic [WIDTH-1:0]  sum_d     [STAGES];
   logic              carry_d   [STAGES];
   logic              overflow_d;

   // Subtraction is a + ~b + 1: invert in1 and force the carry-in once,
   // at the entry to the pipeline.
   mode_e            mode;
   logic [WIDTH-1:0] in1_eff;
   logic             cin_eff;

   assign mode    = mode_e'(sub);
   assign in1_eff = (mode == MODE_SUB) ? ~in1 : in1;
   assign cin_eff = (mode == MODE_SUB) ? 1'b1 : cin;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         logic [SW-1:0] slice_s;
         logic          slice_co;

         if (gi == 0) begin : g_head
            assign a_src[gi]     = in0;
            assign b_src[gi]     = in1_eff;
            assign sum_src[gi]   = '0;
            assign carry_src[gi] = cin_eff;
         end else begin : g_body
            assign a_src[gi]     = a_q[gi-1];
            assign b_src[gi]     = b_q[gi-1];
            assign sum_src[gi]   = sum_q[gi-1];
            assign carry_src[gi] = carry_q[gi-1];
         end

         adder_slice #(
            .SW (SW)
         ) u_slice (
            .a  (a_src[gi][gi*SW +: SW]),
            .b  (b_src[gi][gi*SW +: SW]),
            .ci (carry_src[gi]),
            .s  (slice_s),
            .co (slice_co)
         );

         // Drop this stage's slice into its place in the running sum.
         assign sum_d[gi]   = (sum_src[gi] & ~(SLICE_MASK << (gi*SW)))
                            | (WIDTH'(slice_s) << (gi*SW));
         assign carry_d[gi] = slice_co;

         // The MSB lives in the last slice; the carry into it is recovered
         // from the operand and sum bits at that position.
         if (gi == STAGES-1) begin : g_tail
            assign overflow_d = slice_co
                              ^ (a_src[gi][WIDTH-1] ^ b_src[gi][WIDTH-1] ^ slice_s[SW-1]);
         end
      end
   endgenerate

   // Advance every stage together when enabled; reset wins over enable
   // and drops both in-flight work and any operation offered this cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q    <= '0;
         overflow_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            sum_q[k]   <= '0;
            carry_q[k] <= 1'b0;
         end
      end else if (en) begin
         valid_q[0] <= in_valid;
         for (int k = 1; k < STAGES; k++) begin
            valid_q[k] <= valid_q[k-1];
         end
         overflow_q <= overflow_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]     <= a_src[k];
            b_q[k]     <= b_src[k];
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= carry_d[k];
         end
      end
   end

   assign out       = {carry_q[STAGES-1], sum_q[STAGES-1]};
   assign overflow  = overflow_q;
   assign out_valid = valid_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed checks on an 8-bit, 2-stage adder plus a random sweep over
// several WIDTH/STAGES geometries against a behavioural reference.
module tb_pipelined_adder;
   import pipelined_adder_pkg::*;

   localparam int NCFG   = 9;
   localparam int NSWEEP = 150;

   logic       clk = 1'b0;
   logic       reset, en, in_valid, sub, cin;
   logic [7:0] in0, in1;
   logic [8:0] out;
   logic       overflow, out_valid;

   logic [63:0] sw_in0, sw_in1;
   logic [64:0] sw_out [NCFG];
   logic        sw_ovf [NCFG];
   logic        sw_vld [NCFG];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   function automatic int cfg_w(input int i);
      return (i / 3 == 0) ? 8 : (i / 3 == 1) ? 16 : 32;
   endfunction

   function automatic int cfg_s(input int i);
      return (i % 3 == 0) ? 1 : (i % 3 == 1) ? 2 : cfg_w(i);
   endfunction

   pipelined_adder #(
      .WIDTH  (8),
      .STAGES (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .in_valid  (in_valid),
      .in0       (in0),
      .in1       (in1),
      .sub       (sub),
      .cin       (cin),
      .out       (out),
      .overflow  (overflow),
      .out_valid (out_valid)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NCFG; gi++) begin : g_sweep
         localparam int W = cfg_w(gi);
         localparam int S = cfg_s(gi);
         logic [W:0] o;
         logic       ov, vl;
         pipelined_adder #(
            .WIDTH  (W),
            .STAGES (S)
         ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .en        (en),
            .in_valid  (in_valid),
            .in0       (sw_in0[W-1:0]),
            .in1       (sw_in1[W-1:0]),
            .sub       (sub),
            .cin       (cin),
            .out       (o),
            .overflow  (ov),
            .out_valid (vl)
         );
         assign sw_out[gi] = 65'(o);
         assign sw_ovf[gi] = ov;
         assign sw_vld[gi] = vl;
      end
   endgenerate

   // Reference: plain wide arithmetic, overflow from operand/result signs.
   function automatic void ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                     input logic s, input logic c,
                                     output logic [64:0] o, output logic v);
      logic [65:0] mask, am, bm, sum;
      logic        sa, sb, sr;
      mask = (66'd1 << w) - 66'd1;
      am   = {2'b00, a} & mask;
      bm   = {2'b00, b} & mask;
      if (s) sum = am + ((~bm) & mask) + 66'd1;
      else   sum = am + bm + {65'd0, c};
      o  = sum[64:0] & {mask[63:0], 1'b1};
      sa = am[w-1];
      sb = bm[w-1];
      sr = sum[w-1];
      v  = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; en = 1'b0; in_valid = 1'b1;
      in0 = 8'hAA; in1 = 8'h55; sub = 1'b0; cin = 1'b1;
      sw_in0 = '0; sw_in1 = '0;
      tick();
      tick();
      $display("reset: en=0 in_valid=1 -> out_valid=%b out=%h ovf=%b", out_valid, out, overflow);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
      else n_pass++;
      n_checks++;
      if (out !== 9'h000) $display("FAIL reset_out: got %h want 000", out);
      else n_pass++;
      n_checks++;
      if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow);
      else n_pass++;
      reset = 1'b0; en = 1'b1; in_valid = 1'b0;
   endtask

   // 200 + 100 = 300 = 9'h12C; as signed -56 + 100 = 44, no overflow.
   task automatic test_add();
      in0 = 8'd200; in1 = 8'd100; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL add_early: got %b want 0", out_valid);
      else n_pass++;
      tick();
      $display("add 200+100 -> out=%h ovf=%b valid=%b", out, overflow, out_valid);
      n_checks++;
      if (out_valid !== 1'b1) $display("FAIL add_valid: got %b want 1", out_valid);
      else n_pass++;
      n_checks++;
      if (out !== 9'h12C) $display("FAIL add_out: got %h want 12c", out);
      else n_pass++;
      n_checks++;
      if (overflow !== 1'b0) $display("FAIL add_ovf: got %b want 0", overflow);
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL add_pulse: got %b want 0", out_valid);
      else n_pass++;
   endtask

   task automatic test_sub();
      logic [7:0] ta [2] = '{8'd5, 8'd7};
      logic [7:0] tb [2] = '{8'd7, 8'd5};
      logic [8:0] eo [2] = '{9'h0FE, 9'h102};
      for (int i = 0; i < 2; i++) begin
         in0 = ta[i]; in1 = tb[i]; sub = 1'b1; cin = 1'b1; in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         tick();
         $display("sub %0d-%0d -> out=%h ovf=%b valid=%b", ta[i], tb[i], out, overflow, out_valid);
         n_checks++;
         if (out_valid !== 1'b1) $display("FAIL sub%0d_valid: got %b want 1", i, out_valid);
         else n_pass++;
         n_checks++;
         if (out !== eo[i]) $display("FAIL sub%0d_out: got %h want %h", i, out, eo[i]);
         else n_pass++;
         n_checks++;
         if (overflow !== 1'b0) $display("FAIL sub%0d_ovf: got %b want 0", i, overflow);
         else n_pass++;
      end
   endtask

   // 127+1 overflows to -128; all-ones + all-ones + 1 wraps to 9'h1FF (-1, no overflow).
   task automatic test_wrap();
      logic [7:0] ta [2] = '{8'd127, 8'd255};
      logic [7:0] tb [2] = '{8'd1,   8'd255};
      logic       tc [2] = '{1'b0,   1'b1};
      logic [8:0] eo [2] = '{9'h080, 9'h1FF};
      logic       ev [2] = '{1'b1,   1'b0};
      for (int i = 0; i < 2; i++) begin
         in0 = ta[i]; in1 = tb[i]; sub = 1'b0; cin = tc[i]; in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         tick();
         $display("add %0d+%0d+%0d -> out=%h ovf=%b", ta[i], tb[i], tc[i], out, overflow);
         n_checks++;
         if (out !== eo[i]) $display("FAIL wrap%0d_out: got %h want %h", i, out, eo[i]);
         else n_pass++;
         n_checks++;
         if (overflow !== ev[i]) $display("FAIL wrap%0d_ovf: got %b want %b", i, overflow, ev[i]);
         else n_pass++;
      end
   endtask

   // Four ops back to back, then a 3-cycle stall with junk offered at the inputs.
   task automatic test_back_to_back();
      logic [7:0] ta [4] = '{8'd10,  8'd3,   8'd100, 8'h80};
      logic [7:0] tb [4] = '{8'd20,  8'd10,  8'd100, 8'h01};
      logic       ts [4] = '{1'b0,   1'b1,   1'b0,   1'b1};
      logic       tc [4] = '{1'b0,   1'b0,   1'b1,   1'b0};
      logic [8:0] eo [4] = '{9'h01E, 9'h0F9, 9'h0C9, 9'h17F};
      logic       ev [4] = '{1'b0,   1'b0,   1'b1,   1'b1};
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in0 = ta[i]; in1 = tb[i]; sub = ts[i]; cin = tc[i]; in_valid = 1'b1;
         tick();
         if (i == 0) begin
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL b2b_idle: got %b want 0", out_valid);
            else n_pass++;
         end else begin
            $display("b2b op%0d -> out=%h ovf=%b valid=%b", i-1, out, overflow, out_valid);
            n_checks++;
            if (out_valid !== 1'b1) $display("FAIL b2b%0d_valid: got %b want 1", i-1, out_valid);
            else n_pass++;
            n_checks++;
            if (out !== eo[i-1]) $display("FAIL b2b%0d_out: got %h want %h", i-1, out, eo[i-1]);
            else n_pass++;
            n_checks++;
            if (overflow !== ev[i-1]) $display("FAIL b2b%0d_ovf: got %b want %b", i-1, overflow, ev[i-1]);
            else n_pass++;
         end
      end
      en = 1'b0; in0 = 8'h55; in1 = 8'h33; sub = 1'b0; cin = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         $display("stall %0d -> out=%h ovf=%b valid=%b", k, out, overflow, out_valid);
         n_checks++;
         if (out_valid !== 1'b1) $display("FAIL stall%0d_valid: got %b want 1", k, out_valid);
         else n_pass++;
         n_checks++;
         if (out !== eo[2]) $display("FAIL stall%0d_out: got %h want %h", k, out, eo[2]);
         else n_pass++;
         n_checks++;
         if (overflow !== ev[2]) $display("FAIL stall%0d_ovf: got %b want %b", k, overflow, ev[2]);
         else n_pass++;
      end
      en = 1'b1; in_valid = 1'b0;
      tick();
      $display("b2b op3 -> out=%h ovf=%b valid=%b", out, overflow, out_valid);
      n_checks++;
      if (out_valid !== 1'b1) $display("FAIL b2b3_valid: got %b want 1", out_valid);
      else n_pass++;
      n_checks++;
      if (out !== eo[3]) $display("FAIL b2b3_out: got %h want %h", out, eo[3]);
      else n_pass++;
      n_checks++;
      if (overflow !== ev[3]) $display("FAIL b2b3_ovf: got %b want %b", overflow, ev[3]);
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", out_valid);
      else n_pass++;
   endtask

   // Op in flight plus an op offered with reset are both dropped;
   // the op offered right after reset completes normally (5+6=11).
   task automatic test_reset_flush();
      en = 1'b1;
      in0 = 8'd127; in1 = 8'd1; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      tick();
      in0 = 8'd9; in1 = 8'd2; sub = 1'b1; reset = 1'b1;
      tick();
      $display("flush reset -> out=%h ovf=%b valid=%b", out, overflow, out_valid);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", out_valid);
      else n_pass++;
      n_checks++;
      if (out !== 9'h000) $display("FAIL flush_out: got %h want 000", out);
      else n_pass++;
      n_checks++;
      if (overflow !== 1'b0) $display("FAIL flush_ovf: got %b want 0", overflow);
      else n_pass++;
      reset = 1'b0; in0 = 8'd5; in1 = 8'd6; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL flush_dropped: got %b want 0", out_valid);
      else n_pass++;
      tick();
      $display("post-reset 5+6 -> out=%h ovf=%b valid=%b", out, overflow, out_valid);
      n_checks++;
      if (out_valid !== 1'b1) $display("FAIL post_valid: got %b want 1", out_valid);
      else n_pass++;
      n_checks++;
      if (out !== 9'h00B) $display("FAIL post_out: got %h want 00b", out);
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL post_pulse: got %b want 0", out_valid);
      else n_pass++;
   endtask

   task automatic test_sweep();
      logic [63:0] ha [NSWEEP];
      logic [63:0] hb [NSWEEP];
      logic        hs [NSWEEP];
      logic        hc [NSWEEP];
      logic [64:0] eo;
      logic        ev, expv;
      int          s, w, j;
      reset = 1'b1; en = 1'b1; in_valid = 1'b0;
      tick();
      reset = 1'b0;
      for (int p = 0; p < NSWEEP; p++) begin
         ha[p] = {$urandom, $urandom};
         hb[p] = {$urandom, $urandom};
         if (p % 10 == 3) begin
            ha[p] = '1;
            hb[p] = '1;
         end
         hs[p] = 1'($urandom_range(0, 1));
         hc[p] = 1'($urandom_range(0, 1));
         sw_in0 = ha[p]; sw_in1 = hb[p]; sub = hs[p]; cin = hc[p]; in_valid = 1'b1;
         $display("sweep op %0d a=%h b=%h sub=%b cin=%b", p, ha[p], hb[p], hs[p], hc[p]);
         tick();
         for (int c = 0; c < NCFG; c++) begin
            s = cfg_s(c);
            w = cfg_w(c);
            expv = (p >= s - 1);
            n_checks++;
            if (sw_vld[c] !== expv)
               $display("FAIL sweep_w%0d_s%0d_valid@%0d: got %b want %b", w, s, p, sw_vld[c], expv);
            else n_pass++;
            if (expv) begin
               j = p - s + 1;
               ref_model(w, ha[j], hb[j], hs[j], hc[j], eo, ev);
               n_checks++;
               if (sw_out[c] !== eo)
                  $display("FAIL sweep_w%0d_s%0d_out op%0d: got %h want %h", w, s, j, sw_out[c], eo);
               else n_pass++;
               n_checks++;
               if (sw_ovf[c] !== ev)
                  $display("FAIL sweep_w%0d_s%0d_ovf op%0d: got %b want %b", w, s, j, sw_ovf[c], ev);
               else n_pass++;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_wrap();
      test_back_to_back();
      test_reset_flush();
      test_sweep();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
